// File: rtl/cpu_result_tracer.sv
// Trace capture for the CPU Result bus: stamps each enabled sample with a free-running
// cycle count and queues it in a first-word-fall-through FIFO drained over valid/ready.
module cpu_result_tracer #(
  parameter int DEPTH    = 16,
  parameter int CYC_W    = 16,
  parameter bit ONCHANGE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clear,
  input  logic [31:0]                result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [CYC_W-1:0]           out_cycle,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [CYC_W-1:0] cyc;
    logic [31:0]      data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CYC_W-1:0] cyc;
  logic [31:0]      last_val;
  logic             have_last;
  logic             push_req, pop, full, push_ok, drop;

  assign out_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign push_req  = en && !clear && (!ONCHANGE || !have_last || (result != last_val));
  assign pop       = out_valid && out_ready;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  assign out_data  = mem[rd_ptr].data;
  assign out_cycle = mem[rd_ptr].cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + CYC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= '{cyc: cyc, data: result};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      have_last <= 1'b0;
      last_val  <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      have_last <= 1'b0;
    end else begin
      // the change filter tracks requests, so a dropped sample still updates it
      if (push_req) begin
        last_val  <= result;
        have_last <= 1'b1;
      end
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_cpu_result_tracer.sv
// Bench for cpu_result_tracer: two instances (plain and change-filtered) share stimulus
// and are compared every cycle against a list-based model, plus literal spot checks.
module tb_cpu_result_tracer;
  logic        clk = 1'b0;
  logic        rst;
  logic        en = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic [31:0] result = '0;

  logic        v0, v1, ov0, ov1;
  logic [31:0] d0, d1;
  logic [15:0] c0, c1, dr0, dr1;
  logic [4:0]  n0, n1;

  int n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  cpu_result_tracer #(.DEPTH(16), .CYC_W(16), .ONCHANGE(1'b0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .result(result),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_cycle(c0),
    .count(n0), .overflow(ov0), .drop_cnt(dr0));

  cpu_result_tracer #(.DEPTH(16), .CYC_W(16), .ONCHANGE(1'b1)) u_chg (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .result(result),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_cycle(c1),
    .count(n1), .overflow(ov1), .drop_cnt(dr1));

  // model: ordered list of {stamp, value} per instance, index 0 is the head
  logic [47:0] mq    [2][16];
  int          mcnt  [2] = '{0, 0};
  logic        mov   [2] = '{1'b0, 1'b0};
  logic [15:0] mdrop [2] = '{16'd0, 16'd0};
  logic        mhl   [2] = '{1'b0, 1'b0};
  logic [31:0] mlast [2] = '{32'd0, 32'd0};
  logic [15:0] mcyc = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mcnt[i] = 0; mov[i] = 1'b0; mdrop[i] = '0; mhl[i] = 1'b0;
      end
      mcyc = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit pr, pp;
        pr = en && !clear && (i == 0 || !mhl[i] || result != mlast[i]);
        if (clear) begin
          mcnt[i] = 0; mov[i] = 1'b0; mdrop[i] = '0; mhl[i] = 1'b0;
        end else begin
          pp = (mcnt[i] > 0) && out_ready;
          if (pr) begin mlast[i] = result; mhl[i] = 1'b1; end
          if (pp) begin
            for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
            mcnt[i]--;
          end
          if (pr) begin
            if (mcnt[i] < 16) begin
              mq[i][mcnt[i]] = {mcyc, result};
              mcnt[i]++;
            end else begin
              mov[i] = 1'b1;
              if (mdrop[i] != 16'hFFFF) mdrop[i] = mdrop[i] + 16'd1;
            end
          end
        end
      end
      mcyc = mcyc + 16'd1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic cmp(input int i, input logic v, input logic [4:0] c, input logic ov,
                     input logic [15:0] dr, input logic [31:0] od, input logic [15:0] oc);
    chk($sformatf("m%0d.out_valid", i), 64'(v),  64'(mcnt[i] != 0));
    chk($sformatf("m%0d.count", i),     64'(c),  64'(mcnt[i]));
    chk($sformatf("m%0d.overflow", i),  64'(ov), 64'(mov[i]));
    chk($sformatf("m%0d.drop_cnt", i),  64'(dr), 64'(mdrop[i]));
    if (mcnt[i] > 0) begin
      chk($sformatf("m%0d.out_data", i),  64'(od), 64'(mq[i][0][31:0]));
      chk($sformatf("m%0d.out_cycle", i), 64'(oc), 64'(mq[i][0][47:32]));
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      cmp(0, v0, n0, ov0, dr0, d0, c0);
      cmp(1, v1, n1, ov1, dr1, d1, c1);
    end
  end

  initial begin
    rst = 1'b1;
    #12;
    chk("rst.valid", 64'(v0), 64'(0));
    chk("rst.count", 64'(n0), 64'(0));
    chk("rst.data",  64'(d0), 64'(0));
    chk("rst.cycle", 64'(c0), 64'(0));
    chk("rst.ovf",   64'(ov0), 64'(0));
    chk("rst.drop",  64'(dr1), 64'(0));
    #10;
    rst = 1'b0;

    // three captures, stamps 0..2, then drain
    en = 1'b1; result = 32'd5;
    @(negedge clk); result = 32'd6;
    @(negedge clk); result = 32'd7;
    @(negedge clk); en = 1'b0;
    chk("s1.count", 64'(n0), 64'(3));
    chk("s1.data",  64'(d0), 64'(5));
    chk("s1.cycle", 64'(c0), 64'(0));
    out_ready = 1'b1;
    @(negedge clk);
    chk("s1.pop1.data",  64'(d0), 64'(6));
    chk("s1.pop1.cycle", 64'(c0), 64'(1));
    @(negedge clk);
    chk("s1.pop2.data",  64'(d0), 64'(7));
    chk("s1.pop2.cycle", 64'(c0), 64'(2));
    @(negedge clk);
    chk("s1.empty", 64'(v0), 64'(0));
    out_ready = 1'b0;

    // overflow: 20 pushes into 16 slots
    for (int i = 0; i < 20; i++) begin
      en = 1'b1; result = 32'(100 + i);
      @(negedge clk);
    end
    en = 1'b0;
    chk("ovf.count", 64'(n0), 64'(16));
    chk("ovf.flag",  64'(ov0), 64'(1));
    chk("ovf.drop",  64'(dr0), 64'(4));
    chk("ovf.head",  64'(d0), 64'(100));
    chk("ovf.chg.drop", 64'(dr1), 64'(4));

    // full with simultaneous push and pop
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; result = 32'(200 + i);
      @(negedge clk);
    end
    en = 1'b0; out_ready = 1'b0;
    chk("pp.count", 64'(n0), 64'(16));
    chk("pp.drop",  64'(dr0), 64'(4));
    chk("pp.head",  64'(d0), 64'(105));
    out_ready = 1'b1;
    repeat (17) @(negedge clk);
    out_ready = 1'b0;
    chk("pp.drained", 64'(v0), 64'(0));

    // clear with pending traffic
    for (int i = 0; i < 17; i++) begin
      en = 1'b1; result = 32'(300 + i);
      @(negedge clk);
    end
    en = 1'b0; out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("clr.pre.count", 64'(n0), 64'(4));
    chk("clr.pre.ovf",   64'(ov0), 64'(1));
    clear = 1'b1; en = 1'b1; result = 32'd999;
    @(negedge clk);
    clear = 1'b0; en = 1'b0; out_ready = 1'b0;
    chk("clr.count", 64'(n0), 64'(0));
    chk("clr.valid", 64'(v0), 64'(0));
    chk("clr.ovf",   64'(ov0), 64'(0));
    chk("clr.drop",  64'(dr0), 64'(0));
    en = 1'b1; result = 32'd42;
    @(negedge clk);
    en = 1'b0;
    chk("clr.after.count", 64'(n1), 64'(1));
    chk("clr.after.data",  64'(d1), 64'(42));

    // asynchronous reset while draining eight entries
    for (int i = 0; i < 7; i++) begin
      en = 1'b1; result = 32'(500 + i);
      @(negedge clk);
    end
    en = 1'b0;
    chk("ar.pre.count", 64'(n0), 64'(8));
    out_ready = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar.valid", 64'(v0), 64'(0));
    chk("ar.count", 64'(n0), 64'(0));
    chk("ar.chg.count", 64'(n1), 64'(0));
    #1 rst = 1'b0; out_ready = 1'b0;
    chk("ar.rel.count", 64'(n0), 64'(0));

    // change filter after reset: 3,3,3,9,9,3
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      en = 1'b1;
      result = (i == 3 || i == 4) ? 32'd9 : 32'd3;
      @(negedge clk);
    end
    en = 1'b0;
    chk("chg.count", 64'(n1), 64'(3));
    chk("chg.e0.data",  64'(d1), 64'(3));
    chk("chg.e0.cycle", 64'(c1), 64'(0));
    chk("chg.plain.count", 64'(n0), 64'(6));
    out_ready = 1'b1;
    @(negedge clk);
    chk("chg.e1.data",  64'(d1), 64'(9));
    chk("chg.e1.cycle", 64'(c1), 64'(3));
    @(negedge clk);
    chk("chg.e2.data",  64'(d1), 64'(3));
    chk("chg.e2.cycle", 64'(c1), 64'(5));
    chk("chg.plain.e2.cycle", 64'(c0), 64'(2));
    @(negedge clk);
    chk("chg.empty", 64'(v1), 64'(0));
    out_ready = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
